// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port IDs and
// the default memory depth.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int DEFAULT_DEPTH = 32;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational 2-way round-robin arbiter. On a tie the port that did not
// win last time is granted; a lone requester always wins.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       winner
);

    // NOTE: every output of an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant  = 2'b00;
        winner = PORT_PIPE;
        case (req)
            2'b01:   winner = PORT_PIPE;
            2'b10:   winner = PORT_DBG;
            2'b11:   winner = ~last;
            default: winner = PORT_PIPE;
        endcase
        if (req != 2'b00) grant[winner] = 1'b1;
    end

endmodule

// File: rtl/memory_data_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (port 0)
// and the debug/loader port (port 1), one access every three cycles.
module memory_data_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

    state_t state, state_nxt;

    logic              last;
    logic              owner;
    logic              lat_we;
    logic              lat_err;
    logic [1:0]        grant;
    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic [DATA_W-1:0] rd_cap;

    rr_arbiter_2 u_arb (
        .req    ({req1, req0}),
        .last   (last),
        .grant  (grant),
        .winner (winner)
    );

    assign sel_we       = winner ? we1    : we0;
    assign sel_addr     = winner ? addr1  : addr0;
    assign sel_wdata    = winner ? wdata1 : wdata0;
    // Full-width unsigned compare: high address bits are never dropped.
    assign sel_in_range = sel_addr < DEPTH_LIM;
    assign rd_cap       = mem_read ? mem_readdata : '0;

    always_comb begin
        state_nxt = state;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (grant != 2'b00) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                mem_write = ~lat_err &  lat_we;
                mem_read  = ~lat_err & ~lat_we;
                state_nxt = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                ack0      = (owner == PORT_PIPE);
                ack1      = (owner == PORT_DBG);
                err0      = ack0 & lat_err;
                err1      = ack1 & lat_err;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments only, so every one of them sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last          <= PORT_DBG;
            owner         <= PORT_PIPE;
            lat_we        <= 1'b0;
            lat_err       <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            rdata0        <= '0;
            rdata1        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner   <= winner;
                        lat_we  <= sel_we;
                        lat_err <= ~sel_in_range;
                        // Memory bus is loaded only for real accesses so it holds otherwise.
                        if (sel_in_range) begin
                            mem_address   <= sel_addr;
                            mem_writedata <= sel_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (owner == PORT_DBG) rdata1 <= rd_cap;
                    else                   rdata0 <= rd_cap;
                end
                RESP: begin
                    last <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule
